anchor_reader: RTL and testbench

Read-side counterpart of the octree anchor updater. Given an encoded anchor position, it fetches the parent node's child-valid mask from the tree region of the shared octree SRAM. If the anchor exists, it streams the anchor's FEATURE_LENTH feature words out of the feature region, one word per cycle. It sits between the render/query logic and the SRAM port, which is shared with the updater through external arbitration.

---
 rtl/anchor_reader_if.sv | 42 ++++
 rtl/anchor_reader.sv | 181 ++++++++++++++++++
 tb/tb_anchor_reader.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/anchor_reader_if.sv
// ============================================================================
// Module      : anchor_reader_if
// Description : Request/feature stream and SRAM port bundle for anchor_reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface anchor_reader_if #(
    parameter int DATA_BUS_WIDTH    = 64,
    parameter int ADDR_BUS_WIDTH    = 64,
    parameter int ENCODE_ADDR_WIDTH = 18
);
    logic                         read_anchor;
    logic [ENCODE_ADDR_WIDTH-1:0] pos_encode;
    logic                         busy;
    logic                         read_done;
    logic                         hit;
    logic                         feature_valid;
    logic [3:0]                   feature_idx;
    logic [DATA_BUS_WIDTH-1:0]    feature_out;
    logic                         mem_sram_CEN;
    logic [ADDR_BUS_WIDTH-1:0]    mem_sram_A;
    logic [DATA_BUS_WIDTH-1:0]    mem_sram_D;
    logic                         mem_sram_GWEN;
    logic [DATA_BUS_WIDTH-1:0]    mem_sram_Q;

    // Reader side: accepts requests, owns the SRAM request lines.
    modport master (
        input  read_anchor, pos_encode, mem_sram_Q,
        output busy, read_done, hit, feature_valid, feature_idx, feature_out,
               mem_sram_CEN, mem_sram_A, mem_sram_D, mem_sram_GWEN
    );

    // Environment side: query logic plus the arbitrated SRAM.
    modport slave (
        output read_anchor, pos_encode, mem_sram_Q,
        input  busy, read_done, hit, feature_valid, feature_idx, feature_out,
               mem_sram_CEN, mem_sram_A, mem_sram_D, mem_sram_GWEN
    );
endinterface

`default_nettype wire

// File: rtl/anchor_reader.sv
// ============================================================================
// Module      : anchor_reader
// Description : Looks up an encoded octree anchor and streams its feature words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module anchor_reader #(
    parameter int DATA_BUS_WIDTH     = 64,
    parameter int ADDR_BUS_WIDTH     = 64,
    parameter int FEATURE_LENTH      = 9,
    parameter int CHILDREN_NUM       = 8,
    parameter int LOG_CHILD_NUM      = 3,
    parameter int TREE_LEVEL         = 5,
    parameter int LOG_TREE_LEVEL     = 3,
    parameter int TREE_START_ADDR    = 0,
    parameter int FEATURE_START_ADDR = 1200,
    parameter int ENCODE_ADDR_WIDTH  = LOG_CHILD_NUM*TREE_LEVEL+LOG_TREE_LEVEL
) (
    input  logic           clk,
    input  logic           rst,
    anchor_reader_if.master bus
);
    localparam int AW = ADDR_BUS_WIDTH;
    localparam int EW = ENCODE_ADDR_WIDTH;
    localparam int LW = LOG_TREE_LEVEL;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TREE_RD = 3'd1,
        CHECK   = 3'd2,
        FEAT    = 3'd3,
        DRAIN   = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t          state, state_nxt;
    logic [EW-1:0]   pos_lat;
    logic [AW-1:0]   base_lat;
    logic [3:0]      word_cnt;
    logic            feat_valid;
    logic [3:0]      feat_idx;

    logic            busy, read_done, hit, cen;
    logic [AW-1:0]   addr;

    // Sum of node counts of all levels shallower than lvl.
    function automatic logic [AW-1:0] level_offset(input logic [LW-1:0] lvl);
        logic [AW-1:0] acc;
        logic [AW-1:0] span;
        acc  = '0;
        span = AW'(1);
        for (int i = 0; i < TREE_LEVEL; i++) begin
            if (i < int'(lvl)) acc = acc + span;
            span = span << LOG_CHILD_NUM;
        end
        return acc;
    endfunction

    function automatic logic [AW-1:0] node_index(input logic [EW-1:0] pos,
                                                 input logic [LW-1:0] lvl);
        logic [AW-1:0] n;
        n = '0;
        for (int k = 1; k <= TREE_LEVEL; k++) begin
            if (k <= int'(lvl))
                n = (n << LOG_CHILD_NUM)
                  | AW'(pos[EW-LW-1-(k-1)*LOG_CHILD_NUM -: LOG_CHILD_NUM]);
        end
        return n;
    endfunction

    function automatic logic [LOG_CHILD_NUM-1:0] child_index(input logic [EW-1:0] pos,
                                                             input logic [LW-1:0] lvl);
        logic [LOG_CHILD_NUM-1:0] c;
        c = '0;
        for (int k = 1; k <= TREE_LEVEL; k++) begin
            if (k == int'(lvl))
                c = pos[EW-LW-1-(k-1)*LOG_CHILD_NUM -: LOG_CHILD_NUM];
        end
        return c;
    endfunction

    logic [LW-1:0]           in_lvl;
    logic [LW-1:0]           lvl;
    logic [LW-1:0]           parent_lvl;
    logic [AW-1:0]           parent_addr;
    logic [AW-1:0]           feat_base;
    logic [CHILDREN_NUM-1:0] child_mask;
    logic                    child_hit;

    assign in_lvl      = bus.pos_encode[EW-1 -: LW];
    assign lvl         = pos_lat[EW-1 -: LW];
    assign parent_lvl  = lvl - LW'(1);
    assign parent_addr = AW'(TREE_START_ADDR) + level_offset(parent_lvl)
                       + node_index(pos_lat, parent_lvl);
    assign feat_base   = AW'(FEATURE_START_ADDR)
                       + (level_offset(lvl) + node_index(pos_lat, lvl)) * AW'(FEATURE_LENTH);
    assign child_mask  = bus.mem_sram_Q[CHILDREN_NUM-1:0];
    assign child_hit   = child_mask[child_index(pos_lat, lvl)];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        read_done = 1'b0;
        hit       = 1'b0;
        cen       = 1'b1;
        addr      = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.read_anchor) begin
                    if (in_lvl == '0 || in_lvl > LW'(TREE_LEVEL)) state_nxt = DONE;
                    else                                           state_nxt = TREE_RD;
                end
            end
            TREE_RD: begin
                cen       = 1'b0;
                addr      = parent_addr;
                state_nxt = CHECK;
            end
            CHECK: begin
                state_nxt = child_hit ? FEAT : DONE;
            end
            FEAT: begin
                cen  = 1'b0;
                addr = base_lat + AW'(word_cnt);
                if (word_cnt == 4'(FEATURE_LENTH-1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                read_done = 1'b1;
                hit       = 1'b1;
                state_nxt = IDLE;
            end
            DONE: begin
                read_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The base is captured in CHECK so the multiply stays off the FEAT address path.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_lat    <= '0;
            base_lat   <= '0;
            word_cnt   <= '0;
            feat_valid <= 1'b0;
            feat_idx   <= '0;
        end else begin
            if (state == IDLE && bus.read_anchor) pos_lat <= bus.pos_encode;
            if (state == CHECK) begin
                word_cnt <= '0;
                base_lat <= feat_base;
            end else if (state == FEAT) begin
                word_cnt <= word_cnt + 4'd1;
            end
            feat_valid <= (state == FEAT);
            feat_idx   <= (state == FEAT) ? word_cnt : 4'd0;
        end
    end

    assign bus.busy          = busy;
    assign bus.read_done     = read_done;
    assign bus.hit           = hit;
    assign bus.feature_valid = feat_valid;
    assign bus.feature_idx   = feat_idx;
    assign bus.feature_out   = bus.mem_sram_Q;
    assign bus.mem_sram_CEN  = cen;
    assign bus.mem_sram_A    = addr;
    assign bus.mem_sram_D    = '0;
    assign bus.mem_sram_GWEN = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_anchor_reader.sv
// ============================================================================
// Module      : tb_anchor_reader
// Description : Scoreboarded directed bench for anchor_reader with an SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_anchor_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int          cyc;
        logic [63:0] val;
        int          idx;
    } exp_t;

    exp_t addr_q[$];
    exp_t feat_q[$];
    exp_t done_q[$];
    exp_t mon_e;

    logic [63:0] mem [longint];

    anchor_reader_if #(.DATA_BUS_WIDTH(64), .ADDR_BUS_WIDTH(64), .ENCODE_ADDR_WIDTH(18)) bus ();

    anchor_reader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.mem_sram_CEN == 1'b0)
            bus.mem_sram_Q <= mem.exists(longint'(bus.mem_sram_A)) ?
                              mem[longint'(bus.mem_sram_A)] : 64'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] mkpos(input int l, input int c1, input int c2,
                                          input int c3, input int c4, input int c5);
        return {3'(l), 3'(c1), 3'(c2), 3'(c3), 3'(c4), 3'(c5)};
    endfunction

    // Monitor: every SRAM access, feature word and completion must match the queue head.
    always @(negedge clk) begin
        if (bus.mem_sram_CEN === 1'b0) begin
            chk("sram_access_expected", 64'(addr_q.size() != 0), 64'd1);
            if (addr_q.size() != 0) begin
                mon_e = addr_q.pop_front();
                chk("sram_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk("sram_addr", bus.mem_sram_A, mon_e.val);
                chk("sram_gwen", 64'(bus.mem_sram_GWEN), 64'd1);
                chk("sram_d", bus.mem_sram_D, 64'd0);
            end
        end
        if (bus.feature_valid === 1'b1) begin
            chk("feat_expected", 64'(feat_q.size() != 0), 64'd1);
            if (feat_q.size() != 0) begin
                mon_e = feat_q.pop_front();
                chk("feat_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk("feat_idx", 64'(bus.feature_idx), 64'(mon_e.idx));
                chk("feat_data", bus.feature_out, mon_e.val);
            end
        end
        if (bus.read_done === 1'b1) begin
            chk("done_expected", 64'(done_q.size() != 0), 64'd1);
            chk("busy_at_done", 64'(bus.busy), 64'd1);
            if (done_q.size() != 0) begin
                mon_e = done_q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk("done_hit", 64'(bus.hit), mon_e.val);
            end
        end else begin
            chk("hit_without_done", 64'(bus.hit), 64'd0);
        end
    end

    // kind: 0 illegal level, 1 miss, 2 hit
    task automatic issue(input logic [17:0] pos, input int kind, input logic [63:0] parent,
                         input logic [63:0] base, input logic [63:0] dbase);
        int s;
        @(negedge clk);
        bus.read_anchor = 1'b1;
        bus.pos_encode  = pos;
        s = cyc;
        if (kind > 0) addr_q.push_back('{s + 1, parent, 0});
        if (kind == 2) begin
            for (int i = 0; i < 9; i++) begin
                addr_q.push_back('{s + 3 + i, base + 64'(i), i});
                feat_q.push_back('{s + 4 + i, dbase + 64'(i), i});
            end
        end
        done_q.push_back('{(kind == 2) ? s + 12 : (kind == 1) ? s + 3 : s + 1,
                           64'(kind == 2), 0});
        @(negedge clk);
        bus.read_anchor = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(negedge clk);
        #1;
        chk("addr_q_drained", 64'(addr_q.size()), 64'd0);
        chk("feat_q_drained", 64'(feat_q.size()), 64'd0);
        chk("done_q_drained", 64'(done_q.size()), 64'd0);
        chk("idle_busy", 64'(bus.busy), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},  64'(bus.busy), 64'd0);
        chk({tag, "_done"},  64'(bus.read_done), 64'd0);
        chk({tag, "_hit"},   64'(bus.hit), 64'd0);
        chk({tag, "_fv"},    64'(bus.feature_valid), 64'd0);
        chk({tag, "_fidx"},  64'(bus.feature_idx), 64'd0);
        chk({tag, "_cen"},   64'(bus.mem_sram_CEN), 64'd1);
        chk({tag, "_addr"},  bus.mem_sram_A, 64'd0);
        chk({tag, "_d"},     bus.mem_sram_D, 64'd0);
        chk({tag, "_gwen"},  64'(bus.mem_sram_GWEN), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [17:0] pos_l2;
        pos_l2          = mkpos(2, 0, 0, 3, 1, 0);
        bus.read_anchor = 1'b0;
        bus.pos_encode  = '0;
        mem[1]    = 64'h01;
        mem[0]    = 64'h20;
        mem[1253] = 64'h20;
        for (int i = 0; i < 9; i++) begin
            mem[1281 + i]  = 64'(10 + i);
            mem[1254 + i]  = 64'(100 + i);
            mem[91470 + i] = 64'hA000 + 64'(i);
        end

        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Hits at level 2, level 1 and the deepest level.
        issue(pos_l2, 2, 64'd1, 64'd1281, 64'd10);
        drain(14);
        issue(mkpos(1, 5, 0, 0, 0, 0), 2, 64'd0, 64'd1254, 64'd100);
        drain(14);
        issue(mkpos(5, 1, 2, 3, 4, 5), 2, 64'd1253, 64'd91470, 64'hA000);
        drain(14);

        // Miss: mask bit 0 clear.
        mem[1] = 64'hFE;
        issue(pos_l2, 1, 64'd1, 64'd0, 64'd0);
        drain(6);
        mem[1] = 64'h01;

        // Illegal levels.
        issue(mkpos(0, 1, 1, 1, 1, 1), 0, 64'd0, 64'd0, 64'd0);
        drain(4);
        issue(mkpos(6, 1, 1, 1, 1, 1), 0, 64'd0, 64'd0, 64'd0);
        drain(4);
        issue(mkpos(7, 0, 0, 0, 0, 0), 0, 64'd0, 64'd0, 64'd0);
        drain(4);

        // Second request in cycle 5 must be ignored.
        issue(pos_l2, 2, 64'd1, 64'd1281, 64'd10);
        repeat (4) @(negedge clk);
        bus.read_anchor = 1'b1;
        bus.pos_encode  = mkpos(1, 5, 0, 0, 0, 0);
        @(negedge clk);
        bus.read_anchor = 1'b0;
        drain(12);

        // Reset in cycle 6 aborts the request silently.
        issue(pos_l2, 2, 64'd1, 64'd1281, 64'd10);
        repeat (5) @(negedge clk);
        #1;
        rst = 1'b1;
        addr_q.delete();
        feat_q.delete();
        done_q.delete();
        @(negedge clk);
        #1;
        check_reset_outputs("midreset");
        rst = 1'b0;
        drain(4);
        issue(pos_l2, 2, 64'd1, 64'd1281, 64'd10);
        drain(14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
